// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared constants, category/payout codes and FSM encoding for hand_judge
package poker_pkg;

    localparam int NCARD = 5;
    localparam int NRANK = 13;
    localparam int NSUIT = 4;

    localparam logic [3:0] RANK_MIN = 4'd1;
    localparam logic [3:0] RANK_MAX = 4'd13;
    localparam logic [2:0] SUIT_MIN = 3'd1;
    localparam logic [2:0] SUIT_MAX = 3'd4;

    // Occupancy mask bit r-1 is rank r, so Ace sits at bit0 and 10..K at bits 9..12.
    localparam logic [12:0] ROYAL_MASK = 13'h1E01;

    localparam logic [3:0] CAT_NONE     = 4'd0;
    localparam logic [3:0] CAT_PAIR     = 4'd1;
    localparam logic [3:0] CAT_TWO_PAIR = 4'd2;
    localparam logic [3:0] CAT_TRIPS    = 4'd3;
    localparam logic [3:0] CAT_STRAIGHT = 4'd4;
    localparam logic [3:0] CAT_FLUSH    = 4'd5;
    localparam logic [3:0] CAT_FULL     = 4'd6;
    localparam logic [3:0] CAT_QUADS    = 4'd7;
    localparam logic [3:0] CAT_STR_FL   = 4'd8;
    localparam logic [3:0] CAT_ROYAL    = 4'd9;

    localparam logic [7:0] PAY_NONE     = 8'd0;
    localparam logic [7:0] PAY_PAIR     = 8'd0;
    localparam logic [7:0] PAY_TWO_PAIR = 8'd1;
    localparam logic [7:0] PAY_TRIPS    = 8'd1;
    localparam logic [7:0] PAY_STRAIGHT = 8'd3;
    localparam logic [7:0] PAY_FLUSH    = 8'd4;
    localparam logic [7:0] PAY_FULL     = 8'd10;
    localparam logic [7:0] PAY_QUADS    = 8'd20;
    localparam logic [7:0] PAY_STR_FL   = 8'd25;
    localparam logic [7:0] PAY_ROYAL    = 8'd250;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCAN,
        ST_CLASS,
        ST_DONE
    } state_t;

    function automatic logic [7:0] cat_payout(input logic [3:0] cat);
        case (cat)
            CAT_PAIR:     cat_payout = PAY_PAIR;
            CAT_TWO_PAIR: cat_payout = PAY_TWO_PAIR;
            CAT_TRIPS:    cat_payout = PAY_TRIPS;
            CAT_STRAIGHT: cat_payout = PAY_STRAIGHT;
            CAT_FLUSH:    cat_payout = PAY_FLUSH;
            CAT_FULL:     cat_payout = PAY_FULL;
            CAT_QUADS:    cat_payout = PAY_QUADS;
            CAT_STR_FL:   cat_payout = PAY_STR_FL;
            CAT_ROYAL:    cat_payout = PAY_ROYAL;
            default:      cat_payout = PAY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hand_classify.sv
// rtl/hand_classify.sv - combinational priority encoder from rank statistics to category/payout
// Ports:
//   i_pairs/i_trips/i_quads  ranks seen exactly 2 / exactly 3 / 4 or more times
//   i_distinct               number of occupied ranks
//   i_min/i_max              lowest/highest occupied rank (1..13)
//   i_mask                   occupancy mask, bit r-1 = rank r
//   i_flush                  all cards share card0's suit
//   i_err                    some card was out of range; forces category none
//   o_cat/o_pay              hand category and payout multiplier
import poker_pkg::*;

module hand_classify (
    input  logic [2:0]  i_pairs,
    input  logic [2:0]  i_trips,
    input  logic [2:0]  i_quads,
    input  logic [3:0]  i_distinct,
    input  logic [3:0]  i_min,
    input  logic [3:0]  i_max,
    input  logic [12:0] i_mask,
    input  logic        i_flush,
    input  logic        i_err,
    output logic [3:0]  o_cat,
    output logic [7:0]  o_pay
);

    logic       w_broadway;
    logic       w_straight;
    logic [3:0] w_span;

    // Ace counts low (A-2-3-4-5 spans 4) or high only via the broadway mask;
    // J-Q-K-A-2 spans 12 and matches neither, so wrap-around is excluded.
    assign w_span     = i_max - i_min;
    assign w_broadway = (i_mask == ROYAL_MASK);
    assign w_straight = (i_distinct == 4'd5) && ((w_span == 4'd4) || w_broadway);

    always_comb begin
        o_cat = CAT_NONE;
        if (i_err)                                  o_cat = CAT_NONE;
        else if (w_straight && i_flush && w_broadway) o_cat = CAT_ROYAL;
        else if (w_straight && i_flush)             o_cat = CAT_STR_FL;
        else if (i_quads != 3'd0)                   o_cat = CAT_QUADS;
        else if ((i_trips != 3'd0) && (i_pairs == 3'd1)) o_cat = CAT_FULL;
        else if (i_flush)                           o_cat = CAT_FLUSH;
        else if (w_straight)                        o_cat = CAT_STRAIGHT;
        else if (i_trips != 3'd0)                   o_cat = CAT_TRIPS;
        else if (i_pairs == 3'd2)                   o_cat = CAT_TWO_PAIR;
        else if (i_pairs == 3'd1)                   o_cat = CAT_PAIR;
        o_pay = cat_payout(o_cat);
    end

endmodule

// File: rtl/hand_judge.sv
// rtl/hand_judge.sv - final-hand evaluator: card mux, rank histogram, scan and result registers
// Ports:
//   clock, reset_c        rising-edge clock, asynchronous active-low reset
//   judge_go              start pulse, accepted only in IDLE
//   hold[4:0]             bit i keeps dealt card i, else replacement card i+5
//   Pnum0..9, suit0..9    card ranks (1..13) and suits (1..4) from the generator
//   busy                  high from accept edge until hand_done rises
//   hand_done             one-cycle pulse, results valid from then on
//   hand_cat, payout      category code and payout multiplier
//   card_err              some selected card had an out-of-range rank or suit
import poker_pkg::*;

module hand_judge (
    input  logic       clock,
    input  logic       reset_c,
    input  logic       judge_go,
    input  logic [4:0] hold,
    input  logic [3:0] Pnum0, Pnum1, Pnum2, Pnum3, Pnum4,
    input  logic [3:0] Pnum5, Pnum6, Pnum7, Pnum8, Pnum9,
    input  logic [2:0] suit0, suit1, suit2, suit3, suit4,
    input  logic [2:0] suit5, suit6, suit7, suit8, suit9,
    output logic       busy,
    output logic       hand_done,
    output logic [3:0] hand_cat,
    output logic [7:0] payout,
    output logic       card_err
);

    logic [3:0]  w_pnum [10];
    logic [2:0]  w_suit [10];

    assign w_pnum = '{Pnum0, Pnum1, Pnum2, Pnum3, Pnum4, Pnum5, Pnum6, Pnum7, Pnum8, Pnum9};
    assign w_suit = '{suit0, suit1, suit2, suit3, suit4, suit5, suit6, suit7, suit8, suit9};

    state_t      r_state;
    logic [3:0]  r_rank [NCARD];
    logic [2:0]  r_suit [NCARD];
    logic [2:0]  r_hist [NRANK];
    logic [2:0]  r_idx;
    logic [3:0]  r_scan;
    logic        r_flush;
    logic        r_err;
    logic [3:0]  r_min;
    logic [3:0]  r_max;
    logic [2:0]  r_pairs;
    logic [2:0]  r_trips;
    logic [2:0]  r_quads;
    logic [3:0]  r_distinct;
    logic [12:0] r_mask;
    logic [3:0]  r_cls_cat;
    logic [7:0]  r_cls_pay;
    logic        r_cls_err;

    logic [3:0]  w_cur_rank;
    logic [2:0]  w_cur_suit;
    logic        w_cur_ok;
    logic [3:0]  w_hidx;
    logic [2:0]  w_cnt;
    logic [3:0]  w_rval;
    logic [3:0]  w_cat;
    logic [7:0]  w_pay;

    assign w_cur_rank = r_rank[r_idx];
    assign w_cur_suit = r_suit[r_idx];
    assign w_cur_ok   = (w_cur_rank >= RANK_MIN) && (w_cur_rank <= RANK_MAX) &&
                        (w_cur_suit >= SUIT_MIN) && (w_cur_suit <= SUIT_MAX);
    assign w_hidx     = w_cur_rank - 4'd1;
    assign w_cnt      = r_hist[r_scan];
    assign w_rval     = r_scan + 4'd1;

    hand_classify u_classify (
        .i_pairs    (r_pairs),
        .i_trips    (r_trips),
        .i_quads    (r_quads),
        .i_distinct (r_distinct),
        .i_min      (r_min),
        .i_max      (r_max),
        .i_mask     (r_mask),
        .i_flush    (r_flush),
        .i_err      (r_err),
        .o_cat      (w_cat),
        .o_pay      (w_pay)
    );

    always_ff @(posedge clock or negedge reset_c) begin
        if (!reset_c) begin
            r_state    <= ST_IDLE;
            for (int i = 0; i < NCARD; i++) begin
                r_rank[i] <= '0;
                r_suit[i] <= '0;
            end
            for (int i = 0; i < NRANK; i++) r_hist[i] <= '0;
            r_idx      <= '0;
            r_scan     <= '0;
            r_flush    <= 1'b0;
            r_err      <= 1'b0;
            r_min      <= '0;
            r_max      <= '0;
            r_pairs    <= '0;
            r_trips    <= '0;
            r_quads    <= '0;
            r_distinct <= '0;
            r_mask     <= '0;
            r_cls_cat  <= '0;
            r_cls_pay  <= '0;
            r_cls_err  <= 1'b0;
            busy       <= 1'b0;
            hand_done  <= 1'b0;
            hand_cat   <= '0;
            payout     <= '0;
            card_err   <= 1'b0;
        end else begin
            hand_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (judge_go) begin
                        for (int i = 0; i < NCARD; i++) begin
                            r_rank[i] <= hold[i] ? w_pnum[i] : w_pnum[i+NCARD];
                            r_suit[i] <= hold[i] ? w_suit[i] : w_suit[i+NCARD];
                        end
                        for (int i = 0; i < NRANK; i++) r_hist[i] <= '0;
                        r_idx      <= '0;
                        r_scan     <= '0;
                        r_flush    <= 1'b1;
                        r_err      <= 1'b0;
                        r_min      <= 4'd15;
                        r_max      <= 4'd0;
                        r_pairs    <= '0;
                        r_trips    <= '0;
                        r_quads    <= '0;
                        r_distinct <= '0;
                        r_mask     <= '0;
                        busy       <= 1'b1;
                        r_state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!w_cur_ok) r_err <= 1'b1;
                    else           r_hist[w_hidx] <= r_hist[w_hidx] + 3'd1;
                    if (w_cur_suit != r_suit[0]) r_flush <= 1'b0;
                    if (r_idx == 3'(NCARD - 1)) r_state <= ST_SCAN;
                    r_idx <= r_idx + 3'd1;
                end
                ST_SCAN: begin
                    if (w_cnt == 3'd2) r_pairs <= r_pairs + 3'd1;
                    if (w_cnt == 3'd3) r_trips <= r_trips + 3'd1;
                    // Five identical cards reach a count of 5; they are still scored as quads.
                    if (w_cnt >= 3'd4) r_quads <= r_quads + 3'd1;
                    if (w_cnt != 3'd0) begin
                        r_distinct     <= r_distinct + 4'd1;
                        r_mask[r_scan] <= 1'b1;
                        if (w_rval < r_min) r_min <= w_rval;
                        if (w_rval > r_max) r_max <= w_rval;
                    end
                    if (r_scan == 4'(NRANK - 1)) r_state <= ST_CLASS;
                    r_scan <= r_scan + 4'd1;
                end
                ST_CLASS: begin
                    r_cls_cat <= w_cat;
                    r_cls_pay <= w_pay;
                    r_cls_err <= r_err;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    // The cycle after this edge is the done cycle; the FSM is already
                    // back in IDLE so a held judge_go is taken on the very next edge.
                    hand_cat  <= r_cls_cat;
                    payout    <= r_cls_pay;
                    card_err  <= r_cls_err;
                    hand_done <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_judge.sv
// tb/tb_hand_judge.sv - directed self-checking bench for hand_judge
module tb_hand_judge;

    logic       clock;
    logic       reset_c;
    logic       judge_go;
    logic [4:0] hold;
    logic [3:0] t_rank [10];
    logic [2:0] t_suit [10];
    logic       busy;
    logic       hand_done;
    logic [3:0] hand_cat;
    logic [7:0] payout;
    logic       card_err;

    int n_checks;
    int n_errors;
    int done_first;
    int done_second;
    int done_cnt;

    hand_judge dut (
        .clock     (clock),
        .reset_c   (reset_c),
        .judge_go  (judge_go),
        .hold      (hold),
        .Pnum0     (t_rank[0]), .Pnum1 (t_rank[1]), .Pnum2 (t_rank[2]), .Pnum3 (t_rank[3]), .Pnum4 (t_rank[4]),
        .Pnum5     (t_rank[5]), .Pnum6 (t_rank[6]), .Pnum7 (t_rank[7]), .Pnum8 (t_rank[8]), .Pnum9 (t_rank[9]),
        .suit0     (t_suit[0]), .suit1 (t_suit[1]), .suit2 (t_suit[2]), .suit3 (t_suit[3]), .suit4 (t_suit[4]),
        .suit5     (t_suit[5]), .suit6 (t_suit[6]), .suit7 (t_suit[7]), .suit8 (t_suit[8]), .suit9 (t_suit[9]),
        .busy      (busy),
        .hand_done (hand_done),
        .hand_cat  (hand_cat),
        .payout    (payout),
        .card_err  (card_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Accept at edge N, then run nedges more edges; judge_go is high before
    // edge k when k<=hold_until or k is ex1/ex2. Done pulses are logged by edge.
    task automatic run_hand(input int ex1, input int ex2, input int hold_until, input int nedges);
        done_first  = 0;
        done_second = 0;
        done_cnt    = 0;
        @(negedge clock);
        judge_go = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= nedges; k++) begin
            @(negedge clock);
            judge_go = (k <= hold_until) || (k == ex1) || (k == ex2);
            @(posedge clock);
            #1;
            if (hand_done) begin
                done_cnt++;
                if (done_cnt == 1) done_first = k;
                else if (done_cnt == 2) done_second = k;
            end
        end
        @(negedge clock);
        judge_go = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int cat, input int pay, input int err);
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " latency"}, done_first, 20);
        chk({tag, " cat"}, hand_cat, cat);
        chk({tag, " pay"}, payout, pay);
        chk({tag, " err"}, card_err, err);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_c  = 1'b0;
        judge_go = 1'b0;
        hold     = 5'b11111;
        t_rank   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        t_suit   = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", hand_done, 0);
        chk("reset cat", hand_cat, 0);
        chk("reset pay", payout, 0);
        chk("reset err", card_err, 0);
        @(negedge clock);
        reset_c = 1'b1;

        // Royal flush from held cards; replacements are a different junk hand.
        hold   = 5'b11111;
        t_rank = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4};
        t_suit = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};
        run_hand(0, 0, 0, 24);
        chk_result("royal", 9, 250, 0);

        // Reset in the middle of SCAN clears outputs and kills the pending pulse.
        hold   = 5'b00000;
        t_rank = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd9, 4'd9};
        t_suit = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
        @(negedge clock);
        judge_go = 1'b1;
        @(posedge clock);
        @(negedge clock);
        judge_go = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset_c = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset done", hand_done, 0);
        chk("midreset cat", hand_cat, 0);
        chk("midreset pay", payout, 0);
        chk("midreset err", card_err, 0);
        @(negedge clock);
        reset_c  = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1;
            if (hand_done) done_cnt++;
        end
        chk("midreset no pulse", done_cnt, 0);

        // Full house from replacement cards, run straight after the reset.
        run_hand(0, 0, 0, 24);
        chk_result("fullhouse", 6, 10, 0);

        hold   = 5'b11111;
        t_rank = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        t_suit = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run_hand(0, 0, 0, 24);
        chk_result("wheel", 4, 3, 0);

        t_rank = '{4'd11, 4'd12, 4'd13, 4'd1, 4'd2, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        run_hand(0, 0, 0, 24);
        chk_result("wrap", 0, 0, 0);

        t_rank = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        t_suit = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run_hand(0, 0, 0, 24);
        chk_result("strflush", 8, 25, 0);

        // Five identical cards: quads beats the flush it also forms.
        t_rank = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        t_suit = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
        run_hand(0, 0, 0, 24);
        chk_result("five7", 7, 20, 0);

        // Selected card 2 (replacement) has rank 14.
        hold   = 5'b11011;
        t_rank = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd1, 4'd2, 4'd2, 4'd14, 4'd3, 4'd4};
        t_suit = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run_hand(0, 0, 0, 24);
        chk_result("rank14", 0, 0, 1);

        // Suit 0 only on unselected cards; two pair remains.
        hold   = 5'b11111;
        t_rank = '{4'd2, 4'd2, 4'd5, 4'd5, 4'd9, 4'd0, 4'd14, 4'd0, 4'd15, 4'd0};
        t_suit = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0};
        run_hand(0, 0, 0, 24);
        chk_result("unsel_bad", 2, 1, 0);

        // judge_go while busy (N+3) and in CLASS (N+19) is ignored.
        t_rank = '{4'd4, 4'd4, 4'd4, 4'd9, 4'd12, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        t_suit = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run_hand(3, 19, 0, 40);
        chk_result("busy_go", 3, 1, 0);

        // Results hold across idle cycles and through the next accept edge.
        t_rank = '{4'd2, 4'd5, 4'd7, 4'd9, 4'd12, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        t_suit = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        repeat (10) @(posedge clock);
        #1;
        chk("stable cat", hand_cat, 3);
        @(negedge clock);
        judge_go = 1'b1;
        @(posedge clock);
        #1;
        chk("accept busy", busy, 1);
        chk("accept cat held", hand_cat, 3);
        chk("accept pay held", payout, 1);
        @(negedge clock);
        judge_go = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        chk("flush cat", hand_cat, 5);
        chk("flush pay", payout, 4);

        // judge_go held high: second accept at N+21, second pulse at N+41.
        t_rank = '{4'd8, 4'd8, 4'd3, 4'd3, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        t_suit = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        run_hand(0, 0, 21, 45);
        chk("held done_cnt", done_cnt, 2);
        chk("held first", done_first, 20);
        chk("held second", done_second, 41);
        chk("held cat", hand_cat, 6);
        chk("held busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
